redmule_mx_dec_arbiter: RTL and testbench

Block-level arbiter that shares one MX decoder (E8M0 shared-exponent + 8-bit element block in, one 16-bit element per beat out) between two operand requesters, channel 0 (X) and channel 1 (W). It grants the decoder for a whole MX block, forwards that block's value word and shared exponent to the decoder, and routes the decoded element stream back to the granted channel. It also counts the elements returned, releases the grant after the last one, and reports per-channel block-completion counts to the controller.

---
 rtl/redmule_mx_dec_arbiter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_redmule_mx_dec_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_mx_dec_arbiter.sv
// -----------------------------------------------------------------------------
// redmule_mx_dec_arbiter
//
// Purpose
//   Shares one MX decoder between two operand requesters: channel 0 (X) and
//   channel 1 (W). A requester owns the decoder for one whole MX block. While
//   it owns it, its value word and shared exponent go to the decoder, and the
//   decoded element stream comes back to it. After the last element of the
//   block the grant is released and that channel's completed-block counter
//   advances.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   clear_i               synchronous clear (FSM, counters, priority)
//   chN_val_*             value-block handshake from channel N (DATA_W bits)
//   chN_exp_*             shared-exponent handshake from channel N (8 bits)
//   chN_fp16_*            decoded-element handshake to channel N (BITW bits)
//   dec_val_*, dec_exp_*  block/exponent handshake towards the decoder
//   dec_fp16_*            decoded-element handshake from the decoder
//   grant_o               one-hot owner, 00 while idle
//   busy_o                high while a block is being issued or drained
//   chN_blk_cnt_o         blocks fully delivered to channel N (wraps)
//   state_o               FSM state, for debug and checkers
//
// Configuration
//   REDMULE_MX_ARB_FIXED_PRIO_EN  when defined, channel 0 always wins a tie
//                                 and no priority pointer exists. When
//                                 undefined, ties are resolved round-robin.
//
// Handshake rule (all ports): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. Valid never depends on ready
// on the requester side; this block only passes valid/ready combinationally
// between the owner and the decoder and never creates a transfer itself.
// -----------------------------------------------------------------------------

module redmule_mx_dec_arbiter #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned BITW   = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,

    // Channel 0 (X)
    input  logic              ch0_val_valid_i,
    output logic              ch0_val_ready_o,
    input  logic [DATA_W-1:0] ch0_val_data_i,
    input  logic              ch0_exp_valid_i,
    output logic              ch0_exp_ready_o,
    input  logic [7:0]        ch0_exp_data_i,
    output logic              ch0_fp16_valid_o,
    input  logic              ch0_fp16_ready_i,
    output logic [BITW-1:0]   ch0_fp16_data_o,

    // Channel 1 (W)
    input  logic              ch1_val_valid_i,
    output logic              ch1_val_ready_o,
    input  logic [DATA_W-1:0] ch1_val_data_i,
    input  logic              ch1_exp_valid_i,
    output logic              ch1_exp_ready_o,
    input  logic [7:0]        ch1_exp_data_i,
    output logic              ch1_fp16_valid_o,
    input  logic              ch1_fp16_ready_i,
    output logic [BITW-1:0]   ch1_fp16_data_o,

    // Decoder side
    output logic              dec_val_valid_o,
    input  logic              dec_val_ready_i,
    output logic [DATA_W-1:0] dec_val_data_o,
    output logic              dec_exp_valid_o,
    input  logic              dec_exp_ready_i,
    output logic [7:0]        dec_exp_data_o,
    input  logic              dec_fp16_valid_i,
    output logic              dec_fp16_ready_o,
    input  logic [BITW-1:0]   dec_fp16_data_i,

    // Status
    output logic [1:0]        grant_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  ch0_blk_cnt_o,
    output logic [CNT_W-1:0]  ch1_blk_cnt_o,
    output logic [1:0]        state_o
);

    localparam int unsigned NUM_ELEMS = DATA_W / 8;
    localparam int unsigned ECNT_W    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [ECNT_W-1:0] LAST_ELEM = ECNT_W'(NUM_ELEMS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ECNT_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0]  blk0_cnt_q, blk0_cnt_d;
    logic [CNT_W-1:0]  blk1_cnt_q, blk1_cnt_d;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
    // 0: channel 0 wins a tie, 1: channel 1 wins a tie.
    logic              prio_q, prio_d;
`endif

    logic in_issue;
    logic in_drain;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_drain = (state_q == ST_DRAIN);

    // -------------------------------------------------------------------------
    // Requests and arbitration
    // -------------------------------------------------------------------------
    // Both halves of the block must be offered before a channel competes.
    logic       req0;
    logic       req1;
    logic [1:0] winner;

    assign req0 = ch0_val_valid_i & ch0_exp_valid_i;
    assign req1 = ch1_val_valid_i & ch1_exp_valid_i;

    always_comb begin
        winner = 2'b00;
        if (req0 && req1) begin
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
            winner = 2'b01;
`else
            winner = prio_q ? 2'b10 : 2'b01;
`endif
        end else if (req0) begin
            winner = 2'b01;
        end else if (req1) begin
            winner = 2'b10;
        end
    end

    // -------------------------------------------------------------------------
    // Owner selection. grant_q is one-hot outside IDLE, so bit 1 picks the
    // channel; in IDLE every consumer of these muxes is gated off anyway.
    // -------------------------------------------------------------------------
    logic              sel_ch1;
    logic              own_val_valid;
    logic [DATA_W-1:0] own_val_data;
    logic              own_exp_valid;
    logic [7:0]        own_exp_data;
    logic              own_fp16_ready;

    assign sel_ch1        = grant_q[1];
    assign own_val_valid  = sel_ch1 ? ch1_val_valid_i  : ch0_val_valid_i;
    assign own_val_data   = sel_ch1 ? ch1_val_data_i   : ch0_val_data_i;
    assign own_exp_valid  = sel_ch1 ? ch1_exp_valid_i  : ch0_exp_valid_i;
    assign own_exp_data   = sel_ch1 ? ch1_exp_data_i   : ch0_exp_data_i;
    assign own_fp16_ready = sel_ch1 ? ch1_fp16_ready_i : ch0_fp16_ready_i;

    // -------------------------------------------------------------------------
    // Decoder-facing outputs
    // -------------------------------------------------------------------------
    assign dec_val_valid_o  = in_issue & own_val_valid;
    assign dec_val_data_o   = in_issue ? own_val_data : '0;
    assign dec_exp_valid_o  = in_issue & own_exp_valid;
    assign dec_exp_data_o   = in_issue ? own_exp_data : '0;
    assign dec_fp16_ready_o = in_drain & own_fp16_ready;

    // -------------------------------------------------------------------------
    // Channel-facing outputs: everything towards a non-owner is held at 0.
    // -------------------------------------------------------------------------
    assign ch0_val_ready_o  = in_issue & grant_q[0] & dec_val_ready_i;
    assign ch0_exp_ready_o  = in_issue & grant_q[0] & dec_exp_ready_i;
    assign ch0_fp16_valid_o = in_drain & grant_q[0] & dec_fp16_valid_i;
    assign ch0_fp16_data_o  = (in_drain & grant_q[0]) ? dec_fp16_data_i : '0;

    assign ch1_val_ready_o  = in_issue & grant_q[1] & dec_val_ready_i;
    assign ch1_exp_ready_o  = in_issue & grant_q[1] & dec_exp_ready_i;
    assign ch1_fp16_valid_o = in_drain & grant_q[1] & dec_fp16_valid_i;
    assign ch1_fp16_data_o  = (in_drain & grant_q[1]) ? dec_fp16_data_i : '0;

    // -------------------------------------------------------------------------
    // Events
    // -------------------------------------------------------------------------
    logic blk_hs;     // value and exponent accepted together by the decoder
    logic elem_beat;  // one decoded element handed to the owner
    logic last_beat;  // final element of the current block

    assign blk_hs    = dec_val_valid_o & dec_val_ready_i &
                       dec_exp_valid_o & dec_exp_ready_i;
    assign elem_beat = in_drain & dec_fp16_valid_i & dec_fp16_ready_o;
    assign last_beat = elem_beat & (elem_cnt_q == LAST_ELEM);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        elem_cnt_d = elem_cnt_q;
        blk0_cnt_d = blk0_cnt_q;
        blk1_cnt_d = blk1_cnt_q;
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
        prio_d     = prio_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (winner != 2'b00) begin
                    grant_d = winner;
                    state_d = ST_ISSUE;
                end
            end

            // A requester that drops its valids here is misbehaving; the
            // grant is kept so the block cannot be half-issued to another.
            ST_ISSUE: begin
                if (blk_hs) begin
                    elem_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (elem_beat) begin
                    elem_cnt_d = elem_cnt_q + ECNT_W'(1);
                end
                if (last_beat) begin
                    elem_cnt_d = '0;
                    grant_d    = 2'b00;
                    state_d    = ST_IDLE;
                    if (grant_q[1]) begin
                        blk1_cnt_d = blk1_cnt_q + CNT_W'(1);
                    end else begin
                        blk0_cnt_d = blk0_cnt_q + CNT_W'(1);
                    end
`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
                    // Point away from the channel just served.
                    prio_d = grant_q[0];
`endif
                end
            end

            default: begin
                state_d    = ST_IDLE;
                grant_d    = 2'b00;
                elem_cnt_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. clear_i wins over every other update, even mid-block; the
    // decoder is expected to be reset alongside, so no drain is attempted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            elem_cnt_q <= '0;
            blk0_cnt_q <= '0;
            blk1_cnt_q <= '0;
        end else if (clear_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            elem_cnt_q <= '0;
            blk0_cnt_q <= '0;
            blk1_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            elem_cnt_q <= elem_cnt_d;
            blk0_cnt_q <= blk0_cnt_d;
            blk1_cnt_q <= blk1_cnt_d;
        end
    end

`ifndef REDMULE_MX_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (clear_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign ch0_blk_cnt_o = blk0_cnt_q;
    assign ch1_blk_cnt_o = blk1_cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_redmule_mx_dec_arbiter.sv
// -----------------------------------------------------------------------------
// tb_redmule_mx_dec_arbiter
//
// Bench for redmule_mx_dec_arbiter. The bench plays both requesters and the
// decoder. The decoder model emits, for element k of a block it accepted,
// {shared exponent, byte k of the value word}. A transaction-level reference
// model decides who owns the decoder, what every output should be in each
// cycle, and which elements each channel must receive, in order.
// Honours REDMULE_MX_ARB_FIXED_PRIO_EN for the tie-break rule.
// -----------------------------------------------------------------------------

module tb_redmule_mx_dec_arbiter;

    localparam int DATA_W = 256;
    localparam int BITW   = 16;
    localparam int CNT_W  = 16;
    localparam int NE     = DATA_W / 8;

    // ------------------------------------------------------------------ clock/reset
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------------ DUT signals
    logic              ch0_val_valid_i = 0, ch0_val_ready_o, ch0_exp_valid_i = 0, ch0_exp_ready_o;
    logic [DATA_W-1:0] ch0_val_data_i = '0;
    logic [7:0]        ch0_exp_data_i = '0;
    logic              ch0_fp16_valid_o, ch0_fp16_ready_i = 0;
    logic [BITW-1:0]   ch0_fp16_data_o;
    logic              ch1_val_valid_i = 0, ch1_val_ready_o, ch1_exp_valid_i = 0, ch1_exp_ready_o;
    logic [DATA_W-1:0] ch1_val_data_i = '0;
    logic [7:0]        ch1_exp_data_i = '0;
    logic              ch1_fp16_valid_o, ch1_fp16_ready_i = 0;
    logic [BITW-1:0]   ch1_fp16_data_o;
    logic              dec_val_valid_o, dec_val_ready_i = 0;
    logic [DATA_W-1:0] dec_val_data_o;
    logic              dec_exp_valid_o, dec_exp_ready_i = 0;
    logic [7:0]        dec_exp_data_o;
    logic              dec_fp16_valid_i = 0, dec_fp16_ready_o;
    logic [BITW-1:0]   dec_fp16_data_i = '0;
    logic [1:0]        grant_o;
    logic              busy_o;
    logic [CNT_W-1:0]  ch0_blk_cnt_o, ch1_blk_cnt_o;
    logic [1:0]        dut_state;

    redmule_mx_dec_arbiter #(.DATA_W(DATA_W), .BITW(BITW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .ch0_val_valid_i(ch0_val_valid_i), .ch0_val_ready_o(ch0_val_ready_o),
        .ch0_val_data_i(ch0_val_data_i), .ch0_exp_valid_i(ch0_exp_valid_i),
        .ch0_exp_ready_o(ch0_exp_ready_o), .ch0_exp_data_i(ch0_exp_data_i),
        .ch0_fp16_valid_o(ch0_fp16_valid_o), .ch0_fp16_ready_i(ch0_fp16_ready_i),
        .ch0_fp16_data_o(ch0_fp16_data_o),
        .ch1_val_valid_i(ch1_val_valid_i), .ch1_val_ready_o(ch1_val_ready_o),
        .ch1_val_data_i(ch1_val_data_i), .ch1_exp_valid_i(ch1_exp_valid_i),
        .ch1_exp_ready_o(ch1_exp_ready_o), .ch1_exp_data_i(ch1_exp_data_i),
        .ch1_fp16_valid_o(ch1_fp16_valid_o), .ch1_fp16_ready_i(ch1_fp16_ready_i),
        .ch1_fp16_data_o(ch1_fp16_data_o),
        .dec_val_valid_o(dec_val_valid_o), .dec_val_ready_i(dec_val_ready_i),
        .dec_val_data_o(dec_val_data_o), .dec_exp_valid_o(dec_exp_valid_o),
        .dec_exp_ready_i(dec_exp_ready_i), .dec_exp_data_o(dec_exp_data_o),
        .dec_fp16_valid_i(dec_fp16_valid_i), .dec_fp16_ready_o(dec_fp16_ready_o),
        .dec_fp16_data_i(dec_fp16_data_i),
        .grant_o(grant_o), .busy_o(busy_o),
        .ch0_blk_cnt_o(ch0_blk_cnt_o), .ch1_blk_cnt_o(ch1_blk_cnt_o),
        .state_o(dut_state)
    );

    // ------------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_bad    = 0;
    logic [BITW-1:0] exp_q0[$];
    logic [BITW-1:0] exp_q1[$];

    task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ stimulus state
    bit                has[2];
    int                send[2];
    logic [DATA_W-1:0] src_data[2];
    logic [7:0]        src_exp[2];
    bit                half0 = 0;       // channel 0 offers value only
    bit                bp1 = 0;         // channel 1 ready toggles during drain
    int                stall_left = 0;  // forced decoder-ready stall cycles in issue
    int                p_gen = 100, p_rx = 100, p_dec_vld = 100, p_dec_rdy = 100;
    logic              dec_rdy;

    // decoder model
    bit                dec_has = 0;
    int                dec_k = 0;
    logic [DATA_W-1:0] dec_blk = '0;
    logic [7:0]        dec_exp = '0;

    // reference model
    int                m_owner = -1;
    bit                m_acc = 0;
    int                m_beats = 0;
    int                m_dcyc = 0;
    int                m_prio = 0;
    logic [CNT_W-1:0]  m_cnt0 = '0, m_cnt1 = '0;

    // per-phase measurements taken from DUT outputs
    int                g01 = 0, g10 = 0, n_busy = 0, n_issue = 0, n_rx0 = 0, n_rx1 = 0;
    logic [1:0]        prev_grant = 2'b00;
    logic [1:0]        glog[$];

    function automatic bit rand_pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic phase_reset();
        g01 = 0; g10 = 0; n_busy = 0; n_issue = 0; n_rx0 = 0; n_rx1 = 0;
        glog.delete();
    endtask

    task automatic rx_beat(input int ch, input logic [BITW-1:0] d);
        logic [BITW-1:0] e;
        if (ch == 0) begin
            check_eq("rx0_expected_beat", 384'(exp_q0.size() > 0), 384'(1));
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check_eq("rx0_data", 384'(d), 384'(e));
            end
        end else begin
            check_eq("rx1_expected_beat", 384'(exp_q1.size() > 0), 384'(1));
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check_eq("rx1_data", 384'(d), 384'(e));
            end
        end
    endtask

    // ------------------------------------------------------------------ driver: one cycle
    task automatic step();
        bit in_issue, in_drain, r0, r1;
        logic [1:0] e_grant;
        logic e_busy, e_vr0, e_er0, e_fv0, e_vr1, e_er1, e_fv1, e_dvv, e_dev, e_dfr;
        logic [BITW-1:0] e_fd0, e_fd1;
        logic [DATA_W-1:0] e_dvd, c_dvd;
        logic [7:0] e_ded, c_ded;
        logic c_hs, c_beat, c_rx0, c_rx1;
        logic [BITW-1:0] c_d0, c_d1;

        @(negedge clk_i);
        in_issue = (m_owner >= 0) && !m_acc;
        in_drain = (m_owner >= 0) && m_acc;
        ch0_val_valid_i = has[0];
        ch0_exp_valid_i = has[0] && !half0;
        ch0_val_data_i  = src_data[0];
        ch0_exp_data_i  = src_exp[0];
        ch1_val_valid_i = has[1];
        ch1_exp_valid_i = has[1];
        ch1_val_data_i  = src_data[1];
        ch1_exp_data_i  = src_exp[1];
        dec_rdy = !(in_issue && stall_left > 0) && rand_pct(p_dec_rdy);
        dec_val_ready_i = dec_rdy;
        dec_exp_ready_i = dec_rdy;
        dec_fp16_valid_i = dec_has && !clear_i && rand_pct(p_dec_vld);
        dec_fp16_data_i  = {dec_exp, dec_blk[(dec_k % NE) * 8 +: 8]};
        ch0_fp16_ready_i = rand_pct(p_rx);
        ch1_fp16_ready_i = bp1 ? (m_dcyc % 2 == 1) : rand_pct(p_rx);
        #1;

        // expected outputs from the model
        e_grant = 2'b00; e_busy = 0;
        e_vr0 = 0; e_er0 = 0; e_fv0 = 0; e_vr1 = 0; e_er1 = 0; e_fv1 = 0;
        e_dvv = 0; e_dev = 0; e_dfr = 0; e_fd0 = '0; e_fd1 = '0; e_dvd = '0; e_ded = '0;
        if (m_owner >= 0) begin
            e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
            e_busy  = 1;
        end
        if (in_issue) begin
            if (m_owner == 0) begin e_vr0 = dec_rdy; e_er0 = dec_rdy; end
            else begin e_vr1 = dec_rdy; e_er1 = dec_rdy; end
            e_dvv = (m_owner == 0) ? ch0_val_valid_i : ch1_val_valid_i;
            e_dev = (m_owner == 0) ? ch0_exp_valid_i : ch1_exp_valid_i;
            e_dvd = src_data[m_owner];
            e_ded = src_exp[m_owner];
        end
        if (in_drain) begin
            e_dfr = (m_owner == 0) ? ch0_fp16_ready_i : ch1_fp16_ready_i;
            if (m_owner == 0) begin e_fv0 = dec_fp16_valid_i; e_fd0 = dec_fp16_data_i; end
            else begin e_fv1 = dec_fp16_valid_i; e_fd1 = dec_fp16_data_i; end
        end
        check_eq("outs",
            {44'd0, dec_val_data_o, dec_exp_data_o, ch0_fp16_data_o, ch1_fp16_data_o,
             grant_o, busy_o, ch0_val_ready_o, ch0_exp_ready_o, ch0_fp16_valid_o,
             ch1_val_ready_o, ch1_exp_ready_o, ch1_fp16_valid_o,
             dec_val_valid_o, dec_exp_valid_o, dec_fp16_ready_o, ch0_blk_cnt_o, ch1_blk_cnt_o},
            {44'd0, e_dvd, e_ded, e_fd0, e_fd1, e_grant, e_busy, e_vr0, e_er0, e_fv0,
             e_vr1, e_er1, e_fv1, e_dvv, e_dev, e_dfr, m_cnt0, m_cnt1});

        // capture what the DUT does this cycle
        c_hs   = dec_val_valid_o && dec_val_ready_i && dec_exp_valid_o && dec_exp_ready_i;
        c_beat = dec_fp16_valid_i && dec_fp16_ready_o;
        c_dvd  = dec_val_data_o;
        c_ded  = dec_exp_data_o;
        c_rx0  = ch0_fp16_valid_o && ch0_fp16_ready_i;
        c_rx1  = ch1_fp16_valid_o && ch1_fp16_ready_i;
        c_d0   = ch0_fp16_data_o;
        c_d1   = ch1_fp16_data_o;
        if (grant_o == 2'b01) g01++;
        if (grant_o == 2'b10) g10++;
        if (busy_o) n_busy++;
        if (busy_o && dec_val_valid_o) n_issue++;
        if (grant_o != 2'b00 && prev_grant == 2'b00) glog.push_back(grant_o);
        prev_grant = grant_o;

        @(posedge clk_i);
        if (c_rx0) begin rx_beat(0, c_d0); n_rx0++; end
        if (c_rx1) begin rx_beat(1, c_d1); n_rx1++; end

        if (!rst_ni || clear_i) begin
            m_owner = -1; m_acc = 0; m_beats = 0; m_dcyc = 0; m_prio = 0;
            m_cnt0 = '0; m_cnt1 = '0;
            exp_q0.delete(); exp_q1.delete();
            dec_has = 0; dec_k = 0;
        end else begin
            if (m_owner < 0) begin
                r0 = ch0_val_valid_i && ch0_exp_valid_i;
                r1 = ch1_val_valid_i && ch1_exp_valid_i;
                if (r0 && r1) begin
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
                    m_owner = 0;
`else
                    m_owner = m_prio;
`endif
                end else if (r0) m_owner = 0;
                else if (r1) m_owner = 1;
                m_acc = 0;
            end else if (!m_acc) begin
                if (e_dvv && e_dev && dec_rdy) begin
                    m_acc = 1; m_beats = 0; m_dcyc = 0;
                    for (int k = 0; k < NE; k++) begin
                        if (m_owner == 0) exp_q0.push_back({src_exp[0], src_data[0][k * 8 +: 8]});
                        else              exp_q1.push_back({src_exp[1], src_data[1][k * 8 +: 8]});
                    end
                    has[m_owner] = 0;
                end
                if (stall_left > 0) stall_left--;
            end else begin
                m_dcyc++;
                if (dec_fp16_valid_i && e_dfr) begin
                    m_beats++;
                    if (m_beats == NE) begin
                        if (m_owner == 0) m_cnt0 = m_cnt0 + 1'b1;
                        else              m_cnt1 = m_cnt1 + 1'b1;
                        m_prio = 1 - m_owner;
                        m_owner = -1; m_acc = 0;
                    end
                end
            end
            // decoder model reacts to what the DUT actually presented
            if (c_hs) begin
                dec_has = 1; dec_k = 0; dec_blk = c_dvd; dec_exp = c_ded;
            end else if (c_beat && dec_has) begin
                dec_k++;
                if (dec_k == NE) dec_has = 0;
            end
        end

        for (int ch = 0; ch < 2; ch++) begin
            if (rst_ni && !has[ch] && send[ch] > 0 && rand_pct(p_gen)) begin
                for (int w = 0; w < DATA_W / 32; w++) src_data[ch][w * 32 +: 32] = $urandom();
                src_exp[ch] = 8'($urandom_range(255, 0));
                has[ch] = 1;
                send[ch]--;
            end
        end
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while (!(m_owner < 0 && !has[0] && !has[1] && send[0] == 0 && send[1] == 0) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 384'(n < budget), 384'(1));
    endtask

    task automatic set_knobs(input int gen, input int rx, input int dv, input int dr);
        p_gen = gen; p_rx = rx; p_dec_vld = dv; p_dec_rdy = dr;
    endtask

    // ------------------------------------------------------------------ test sequence
    logic [1:0] exp_seq[4];
    int exp_c0, exp_c1, n;

    initial begin
        has[0] = 0; has[1] = 0; send[0] = 0; send[1] = 0;
        src_data[0] = '0; src_data[1] = '0; src_exp[0] = '0; src_exp[1] = '0;

        // reset: all outputs low while held
        step(); step();
        rst_ni = 1'b1;
        check_eq("reset_cnt0", 384'(ch0_blk_cnt_o), 384'(0));
        check_eq("reset_cnt1", 384'(ch1_blk_cnt_o), 384'(0));
        check_eq("reset_grant", 384'(grant_o), 384'(0));

        // value valid without exponent valid is not a request
        set_knobs(100, 100, 100, 100);
        half0 = 1; send[0] = 1;
        phase_reset();
        for (int i = 0; i < 10; i++) step();
        check_eq("half_req_busy_cycles", 384'(n_busy), 384'(0));
        check_eq("half_req_grant", 384'(grant_o), 384'(0));

        // single channel-0 block, no backpressure
        half0 = 0;
        phase_reset();
        run_until_idle("single_idle", 200);
        check_eq("single_grant01_cycles", 384'(g01), 384'(1 + NE));
        check_eq("single_rx0_beats", 384'(n_rx0), 384'(NE));
        check_eq("single_rx1_beats", 384'(n_rx1), 384'(0));
        check_eq("single_cnt0", 384'(ch0_blk_cnt_o), 384'(1));

        // decoder stalls the block handshake for 5 cycles
        phase_reset();
        stall_left = 5; send[0] = 1;
        run_until_idle("stall_idle", 200);
        check_eq("stall_issue_cycles", 384'(n_issue), 384'(6));
        check_eq("stall_cnt0", 384'(ch0_blk_cnt_o), 384'(2));

        // channel 1 ready toggles every cycle
        phase_reset();
        bp1 = 1; send[1] = 1;
        run_until_idle("bp_idle", 300);
        bp1 = 0;
        check_eq("bp_grant10_cycles", 384'(g10), 384'(1 + 2 * NE));
        check_eq("bp_rx1_beats", 384'(n_rx1), 384'(NE));
        check_eq("bp_cnt1", 384'(ch1_blk_cnt_o), 384'(1));

        // both channels requesting continuously for 4 blocks
        clear_i = 1'b1; send[0] = 100; send[1] = 100;
        step();
        clear_i = 1'b0;
        phase_reset();
        n = 0;
        while ((int'(m_cnt0) + int'(m_cnt1)) < 4 && n < 1000) begin step(); n++; end
        check_eq("rr_done", 384'(n < 1000), 384'(1));
`ifdef REDMULE_MX_ARB_FIXED_PRIO_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
        exp_c0 = 4; exp_c1 = 0;
`else
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        exp_c0 = 2; exp_c1 = 2;
`endif
        check_eq("rr_grant_count", 384'(glog.size() >= 4), 384'(1));
        for (int i = 0; i < 4; i++) check_eq($sformatf("rr_grant%0d", i), 384'(glog[i]), 384'(exp_seq[i]));
        check_eq("rr_cnt0", 384'(ch0_blk_cnt_o), 384'(exp_c0));
        check_eq("rr_cnt1", 384'(ch1_blk_cnt_o), 384'(exp_c1));
        send[0] = 0; send[1] = 0;
        run_until_idle("rr_flush_idle", 1000);

        // clear in the middle of a block, at element 10
        send[0] = 1;
        n = 0;
        while (!(m_acc && m_beats == 10) && n < 200) begin step(); n++; end
        check_eq("clr_reached_elem10", 384'(n < 200), 384'(1));
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_eq("clr_grant", 384'(grant_o), 384'(0));
        check_eq("clr_busy", 384'(busy_o), 384'(0));
        check_eq("clr_cnt0", 384'(ch0_blk_cnt_o), 384'(0));
        check_eq("clr_cnt1", 384'(ch1_blk_cnt_o), 384'(0));
        phase_reset();
        send[1] = 1;
        run_until_idle("clr_ch1_idle", 200);
        check_eq("clr_first_grant", 384'(glog.size() > 0 ? glog[0] : 2'b00), 384'(2'b10));

        // randomized soak
        set_knobs(60, 70, 75, 60);
        send[0] = int'($urandom_range(8, 4));
        send[1] = int'($urandom_range(8, 4));
        for (int i = 0; i < 500; i++) step();
        send[0] = 0; send[1] = 0;
        run_until_idle("soak_idle", 4000);
        check_eq("soak_q0_empty", 384'(exp_q0.size()), 384'(0));
        check_eq("soak_q1_empty", 384'(exp_q1.size()), 384'(0));
        step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
